// File: rtl/mem_stall_controller_pkg.sv
// ============================================================================
// Module   : mem_stall_controller_pkg
// Brief    : Shared state encoding and default widths for the MEM-stage
//            data-memory stall controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stall_controller_pkg;

    localparam int c_defAddrW = 32;
    localparam int c_defDataW = 32;

    // Replicated to DATA_W bits to form the read data returned on a timeout abort
    localparam logic c_abortFill = 1'b1;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_DONE = 2'd2
    } msState_e;

endpackage

`default_nettype wire

// File: rtl/mem_stall_timeout_counter.sv
// ============================================================================
// Module   : mem_stall_timeout_counter
// Brief    : Counts WAIT cycles; expired flags the TIMEOUT-th WAIT cycle.
//            Built only when MEM_STALL_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef MEM_STALL_TIMEOUT_EN
module mem_stall_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstN,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int c_cntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [c_cntW-1:0] r_count;

    // r_count holds the number of WAIT cycles already completed
    assign expired = enable && (r_count == c_cntW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`endif

`default_nettype wire

// File: rtl/mem_stall_controller.sv
// ============================================================================
// Module   : mem_stall_controller
// Brief    : MEM-stage handshake controller; freezes the pipeline while a
//            variable-latency data memory completes a load or store.
// Options  : MEM_STALL_TIMEOUT_EN adds a TIMEOUT-cycle abort of WAIT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stall_controller
    import mem_stall_controller_pkg::*;
#(
    parameter int ADDR_W  = c_defAddrW,
    parameter int DATA_W  = c_defDataW,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              exMemMemRead,
    input  logic              exMemMemWrite,
    input  logic [ADDR_W-1:0] exMemAddr,
    input  logic [DATA_W-1:0] exMemWriteData,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic              memReady,
    input  logic [DATA_W-1:0] memRdata,
    output logic              pipeFreeze,
    output logic [DATA_W-1:0] memReadData,
    output logic              memDataValid,
    output logic              memError
);

    msState_e          r_state;
    msState_e          w_stateNext;
    logic              w_freeze;
    logic              w_op;
    logic              w_inWait;
    logic              w_abort;

    logic              r_memReq;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic [DATA_W-1:0] r_memReadData;
    logic              r_memDataValid;

    assign w_op     = exMemMemRead | exMemMemWrite;
    assign w_inWait = (r_state == MS_WAIT);

`ifdef MEM_STALL_TIMEOUT_EN
    logic w_expired;
    logic r_memError;

    mem_stall_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeoutCounter (
        .clk     (clk),
        .rstN    (rstN),
        .clear   (!w_inWait),
        .enable  (w_inWait),
        .expired (w_expired)
    );

    // A response arriving on the expiry cycle still completes normally
    assign w_abort = w_expired && !memReady;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_memError <= 1'b0;
        end else begin
            r_memError <= w_inWait && w_abort;
        end
    end

    assign memError = r_memError;
`else
    assign w_abort  = 1'b0;
    assign memError = 1'b0;

    // TIMEOUT only matters for the abort build; values below 1 are invalid
    if (TIMEOUT < 1) begin : g_invalidTimeout
    end
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= MS_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_freeze    = 1'b0;
        case (r_state)
            MS_IDLE: begin
                if (w_op) begin
                    w_freeze    = 1'b1;
                    w_stateNext = MS_WAIT;
                end
            end
            MS_WAIT: begin
                w_freeze = 1'b1;
                if (memReady || w_abort) begin
                    w_stateNext = MS_DONE;
                end
            end
            // An op still visible in DONE is the completed instruction
            MS_DONE: w_stateNext = MS_IDLE;
            default: w_stateNext = MS_IDLE;
        endcase
    end

    // Reset must release the pipeline even if an op is still presented
    assign pipeFreeze = rstN & w_freeze;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_memReq       <= 1'b0;
            r_memWe        <= 1'b0;
            r_memAddr      <= '0;
            r_memWdata     <= '0;
            r_memReadData  <= '0;
            r_memDataValid <= 1'b0;
        end else begin
            r_memDataValid <= 1'b0;
            case (r_state)
                MS_IDLE: begin
                    if (w_op) begin
                        r_memReq   <= 1'b1;
                        r_memWe    <= exMemMemWrite;
                        r_memAddr  <= exMemAddr;
                        r_memWdata <= exMemWriteData;
                    end
                end
                MS_WAIT: begin
                    if (memReady) begin
                        r_memReq       <= 1'b0;
                        r_memDataValid <= 1'b1;
                        if (!r_memWe) begin
                            r_memReadData <= memRdata;
                        end
                    end else if (w_abort) begin
                        r_memReq       <= 1'b0;
                        r_memDataValid <= 1'b1;
                        if (!r_memWe) begin
                            r_memReadData <= {DATA_W{c_abortFill}};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign memReq       = r_memReq;
    assign memWe        = r_memWe;
    assign memAddr      = r_memAddr;
    assign memWdata     = r_memWdata;
    assign memReadData  = r_memReadData;
    assign memDataValid = r_memDataValid;

endmodule

`default_nettype wire

// File: tb/tb_mem_stall_controller.sv
// ============================================================================
// Module   : tb_mem_stall_controller
// Brief    : Scoreboard bench for mem_stall_controller with a latency-
//            programmable memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stall_controller;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk            = 1'b0;
    logic          rstN           = 1'b1;
    logic          exMemMemRead   = 1'b0;
    logic          exMemMemWrite  = 1'b0;
    logic [AW-1:0] exMemAddr      = '0;
    logic [DW-1:0] exMemWriteData = '0;
    logic          memReq;
    logic          memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic          memReady       = 1'b0;
    logic [DW-1:0] memRdata       = '0;
    logic          pipeFreeze;
    logic [DW-1:0] memReadData;
    logic          memDataValid;
    logic          memError;

    always #5 clk = ~clk;

    mem_stall_controller #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rstN           (rstN),
        .exMemMemRead   (exMemMemRead),
        .exMemMemWrite  (exMemMemWrite),
        .exMemAddr      (exMemAddr),
        .exMemWriteData (exMemWriteData),
        .memReq         (memReq),
        .memWe          (memWe),
        .memAddr        (memAddr),
        .memWdata       (memWdata),
        .memReady       (memReady),
        .memRdata       (memRdata),
        .pipeFreeze     (pipeFreeze),
        .memReadData    (memReadData),
        .memDataValid   (memDataValid),
        .memError       (memError)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sbQ[$];
    exp_t        monE;
    int          nTests   = 0;
    int          nFail    = 0;
    int          cycNo    = 0;
    int          memLat   = 0;
    logic [31:0] memData  = '0;
    logic [31:0] expAddr  = '0;
    logic [31:0] expWdata = '0;
    logic        expWe    = 1'b0;
    int          waitCnt  = 0;
    int          reqLen   = 0;
    int          reqCount = 0;
    int          reqStart = 0;
    int          lastDone = 0;
    logic [31:0] mdlRd    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) cycNo <= cycNo + 1;

    // Memory model: raises memReady on the memLat-th cycle of a request (0 = never)
    always @(negedge clk) begin
        if (rstN && memReq) begin
            if (waitCnt == 0) begin
                reqCount++;
                reqStart = cycNo;
            end
            waitCnt++;
            reqLen = waitCnt;
            chk("reqAddrStable", memAddr, expAddr);
            chk("reqWeStable", 32'(memWe), 32'(expWe));
            chk("reqWdataStable", memWdata, expWdata);
            memReady = (memLat != 0) && (waitCnt == memLat);
            memRdata = memReady ? memData : 32'hBAD0BAD0;
        end else begin
            waitCnt  = 0;
            memReady = 1'b0;
            memRdata = 32'hBAD0BAD0;
        end
    end

    // Scoreboard monitor: every completion pops one expected response
    always @(negedge clk) begin
        if (rstN && memDataValid) begin
            lastDone = cycNo;
            if (sbQ.size() == 0) begin
                chk("unexpectedDone", 32'd1, 32'd0);
            end else begin
                monE = sbQ.pop_front();
                chk("doneReadData", memReadData, monE.data);
                chk("doneError", 32'(memError), 32'(monE.err));
            end
        end else if (rstN && memError) begin
            chk("strayError", 32'd1, 32'd0);
        end
    end

    task automatic clearInputs();
        exMemMemRead   = 1'b0;
        exMemMemWrite  = 1'b0;
        exMemAddr      = '0;
        exMemWriteData = '0;
    endtask

    task automatic doOp(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat, input logic [31:0] rdata,
                        input int expFreeze, input logic expErr, input string name);
        int   freeze;
        int   cyc;
        bit   done;
        exp_t e;
        freeze = 0;
        cyc    = 0;
        done   = 1'b0;
        @(negedge clk);
        exMemMemRead   = rd;
        exMemMemWrite  = wr;
        exMemAddr      = addr;
        exMemWriteData = wdata;
        memLat         = lat;
        memData        = rdata;
        expAddr        = addr;
        expWdata       = wdata;
        expWe          = wr;
        if (!wr) mdlRd = expErr ? 32'hFFFF_FFFF : rdata;
        e.data = mdlRd;
        e.err  = expErr;
        sbQ.push_back(e);
        while (!done && cyc < 64) begin
            #1;
            if (pipeFreeze) freeze++;
            if (memDataValid) begin
                done = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({name, "Done"}, 32'(done), 32'd1);
        chk({name, "Freeze"}, 32'(freeze), 32'(expFreeze));
        chk({name, "ReqLen"}, 32'(reqLen), 32'(expFreeze - 1));
    endtask

    initial begin
        int n0;
        int d0;
        // An op visible during reset must not freeze the pipeline
        exMemMemRead = 1'b1;
        #2 rstN = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rstFreeze", 32'(pipeFreeze), 32'd0);
        chk("rstReq", 32'(memReq), 32'd0);
        chk("rstWe", 32'(memWe), 32'd0);
        chk("rstAddr", memAddr, 32'd0);
        chk("rstWdata", memWdata, 32'd0);
        chk("rstReadData", memReadData, 32'd0);
        chk("rstValid", 32'(memDataValid), 32'd0);
        chk("rstError", 32'(memError), 32'd0);
        clearInputs();
        rstN = 1'b1;
        @(negedge clk);
        #1;
        chk("idleFreeze", 32'(pipeFreeze), 32'd0);
        chk("idleReq", 32'(memReq), 32'd0);

        doOp(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 2, 1'b0, "load1");
        clearInputs();
        doOp(1'b0, 1'b1, 32'h200, 32'h0000CAFE, 4, 32'h77777777, 5, 1'b0, "store4");
        clearInputs();

        n0 = reqCount;
        doOp(1'b1, 1'b0, 32'h300, 32'h0, 2, 32'h11111111, 3, 1'b0, "b2bA");
        d0 = lastDone;
        doOp(1'b1, 1'b0, 32'h304, 32'h0, 2, 32'h22222222, 3, 1'b0, "b2bB");
        chk("b2bReqGap", 32'(reqStart - d0), 32'd2);
        chk("b2bReqCount", 32'(reqCount - n0), 32'd2);
        clearInputs();

        doOp(1'b1, 1'b1, 32'h400, 32'h12345678, 3, 32'h33333333, 4, 1'b0, "rdwr");
        clearInputs();
        doOp(1'b1, 1'b0, 32'h500, 32'h0, 3, 32'hA5A5A5A5, 4, 1'b0, "load3");
        clearInputs();

        // Reset during WAIT of a latency-10 load
        @(negedge clk);
        exMemMemRead = 1'b1;
        exMemAddr    = 32'h600;
        memLat       = 10;
        expAddr      = 32'h600;
        expWdata     = 32'h0;
        expWe        = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("midWaitReq", 32'(memReq), 32'd1);
        rstN = 1'b0;
        #1;
        chk("midRstReq", 32'(memReq), 32'd0);
        chk("midRstFreeze", 32'(pipeFreeze), 32'd0);
        chk("midRstReadData", memReadData, 32'd0);
        chk("midRstValid", 32'(memDataValid), 32'd0);
        mdlRd = 32'h0;
        @(negedge clk);
        rstN = 1'b1;
        clearInputs();
        #1;
        chk("postRstFreeze", 32'(pipeFreeze), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("postRstReq", 32'(memReq), 32'd0);

`ifdef MEM_STALL_TIMEOUT_EN
        doOp(1'b1, 1'b0, 32'h700, 32'h0, 0, 32'h0, TO + 1, 1'b1, "timeout");
        clearInputs();
        doOp(1'b1, 1'b0, 32'h704, 32'h0, TO, 32'h5A5A5A5A, TO + 1, 1'b0, "edgeReady");
        clearInputs();
`endif

        repeat (3) @(negedge clk);
        chk("sbEmpty", 32'(sbQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stall_controller.md
Name: mem_stall_controller

Overview:
- MEM-stage data-memory handshake controller for the five-stage pipeline.
- Load-use hazards stall the front end from ID. This block is the back-end counterpart: it stalls the whole pipeline from MEM while a variable-latency data memory completes a load or store.
- Sits between the EX/MEM pipeline register and the data memory port.
- Drives pipeFreeze to every pipeline register and to PC write-enable.

Parameters:
- ADDR_W, 32: data address width.
- DATA_W, 32: data word width.
- TIMEOUT, 255: maximum WAIT cycles before abort; used only with the optional feature; must be at least 1.

Ports:
- clk, input, 1: rising-edge clock.
- rstN, input, 1: asynchronous active-low reset.
- exMemMemRead, input, 1: instruction in MEM is a load.
- exMemMemWrite, input, 1: instruction in MEM is a store.
- exMemAddr, input, ADDR_W: effective address.
- exMemWriteData, input, DATA_W: store data.
- memReq, output, 1: request to memory; held until accepted.
- memWe, output, 1: 1 = write request, 0 = read request.
- memAddr, output, ADDR_W: request address.
- memWdata, output, DATA_W: request write data.
- memReady, input, 1: memory completes the request this cycle.
- memRdata, input, DATA_W: read data, valid when memReady=1.
- pipeFreeze, output, 1: hold PC and all pipeline registers this cycle.
- memReadData, output, DATA_W: registered load result for MEM/WB.
- memDataValid, output, 1: memReadData/completion valid this cycle.
- memError, output, 1: timeout abort pulse (optional feature only; otherwise tied 0).

Behaviour:
- Reset (rstN=0, asynchronous):
  - state=IDLE.
  - memReq=0, memWe=0, memAddr=0, memWdata=0, memReadData=0.
  - memDataValid=0, memError=0.
  - Wait counter=0.
  - pipeFreeze=0 while in reset.
- States: IDLE, WAIT, DONE. Two-bit encoding: IDLE=0, WAIT=1, DONE=2; code 3 recovers to IDLE.
- op = exMemMemRead | exMemMemWrite.
- IDLE:
  - If op=1: pipeFreeze=1 combinationally in the same cycle.
  - On that edge: latch memAddr=exMemAddr, memWdata=exMemWriteData, memWe=exMemMemWrite; set memReq=1; go to WAIT.
  - If both read and write are asserted, the request is a write.
  - If op=0: no action, pipeFreeze=0.
  - memReady is ignored in IDLE.
- WAIT:
  - pipeFreeze=1.
  - memReq, memWe, memAddr and memWdata stay stable every cycle until acceptance.
  - When memReady=1 is sampled: memReq=0 next cycle; memReadData=memRdata if read, unchanged if write; go to DONE.
  - memReady in the same cycle that WAIT is first entered counts as accepted. Minimum memory latency is 1 cycle.
- DONE:
  - Lasts exactly 1 cycle.
  - pipeFreeze=0, memDataValid=1; the pipeline advances at the end of this cycle.
  - Always returns to IDLE. An op visible during DONE belongs to the already-completed instruction and is never re-issued.
- Latency: a load or store with memory latency N (N ≥ 1) freezes the pipeline for N+1 cycles. This is 1 freeze cycle in IDLE plus N in WAIT. DONE is one further unfrozen cycle.
- Back-to-back memory ops: the next instruction is seen in IDLE the cycle after DONE. There is no gap beyond DONE.
- Reset mid-WAIT: memReq drops immediately (asynchronous); the outstanding request is abandoned. The memory is responsible for discarding it.
- pipeFreeze is the only combinational output. All other outputs are registered.

Optional Feature:
- Macro: MEM_STALL_TIMEOUT_EN.
- Defined:
  - The wait counter counts cycles in WAIT.
  - When count reaches TIMEOUT with no memReady: memReq=0, go to DONE with memError=1 for that one cycle.
  - On a read abort, memReadData = all ones.
  - The counter clears on entering WAIT.
  - If memReady arrives in the same cycle the count reaches TIMEOUT, normal completion wins and memError=0.
- Not defined: no counter is instantiated; WAIT is unbounded; memError is tied 0.

Decomposition:
- Shared package: state encoding constants (MS_IDLE, MS_WAIT, MS_DONE), default ADDR_W/DATA_W, and the all-ones abort data constant.
- Sub-module: mem_stall_timeout_counter. Inputs: clear, enable. Output: expired, asserted at TIMEOUT. Instantiated only under MEM_STALL_TIMEOUT_EN.

Test Plan:
- Load, memory latency 1:
  - Stimulus: exMemMemRead=1, addr=0x100, memReady=1 in the first WAIT cycle, memRdata=0xDEADBEEF.
  - Required: pipeFreeze high exactly 2 cycles; memReadData=0xDEADBEEF with memDataValid=1 in DONE.
- Store, latency 4:
  - Stimulus: write 0x0000CAFE to 0x200.
  - Required: memReq/memWe=1 and addr/data stable for 4 cycles; pipeFreeze high 5 cycles; memReadData unchanged.
- Back-to-back loads, latency 2 each:
  - Required: two separate requests; second memReq rises 2 cycles after the first DONE; total freeze 6 cycles.
- Read and write both asserted:
  - Required: memWe=1; store completes normally.
- Reset mid-WAIT:
  - Stimulus: rstN low for 1 cycle during WAIT of a latency-10 load.
  - Required: memReq and pipeFreeze drop immediately; state IDLE; memReadData=0.
- With MEM_STALL_TIMEOUT_EN and TIMEOUT=8:
  - Stimulus: memReady never asserted.
  - Required: memError=1 exactly 1 cycle in DONE; memReadData=0xFFFFFFFF; freeze ends.
